dmem_bus_responder: RTL and testbench
=====================================

// Module: dmem_bus_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory interface. Accepts load/store requests over a
//  valid/ready handshake, stores words in an internal word-addressed array, builds store byte lanes
//  from funct3, formats loads by sign or zero extension, and returns a response once per request.
//  Sits behind the memory stage and replaces the single-cycle data memory where wait states are needed.
// PARAMETERS
//  DATA_WIDTH   32  data/address width, from defines
//  DEPTH_WORDS  1024  number of 32-bit words; word index = addr[log2(DEPTH_WORDS)+1:2]
//  WAIT_CYCLES  2  extra cycles between accept and response, 0..15
// PORTS
//  clk        in   1           clock, all state changes on rising edge
//  rst        in   1           synchronous reset, active-high
//  req_valid  in   1           request present
//  req_ready  out  1           responder can accept a request
//  req_we     in   1           1 = store, 0 = load
//  req_funct3 in   3           instruction[14:12]
//  req_addr   in   DATA_WIDTH  byte address
//  req_wdata  in   DATA_WIDTH  store data, right-aligned
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           requester takes response
//  rsp_rdata  out  DATA_WIDTH  formatted load data; 0 for stores
//  rsp_err    out  1           misaligned or illegal funct3 (trap build only)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//    Memory array contents are not reset. Reset mid-transaction drops it with no response.
//    A pending store commits only if its ACCESS edge came before reset.
//  - FSM: IDLE -> (req_valid&&req_ready) latch we/funct3/addr/wdata -> WAIT -> ACCESS -> RESP -> IDLE.
//    - WAIT is skipped when WAIT_CYCLES=0.
//    - WAIT: the counter loads WAIT_CYCLES-1 and decrements to 0, then moves to ACCESS.
//  - req_ready=1 only in IDLE. Back-to-back requests are therefore separated by at least one IDLE cycle.
//  - ACCESS: one cycle for array read or byte-enable write; the load result is registered into rsp_rdata.
//  - RESP: rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid&&rsp_ready: -> IDLE.
//  - Latency: accept edge to rsp_valid = WAIT_CYCLES+2 cycles.
//  - Store lanes (addr[1:0]=o):
//    - SB: be=1<<o, data byte replicated.
//    - SH: be=2'b11<<o, halfword replicated.
//    - SW: be=4'hF.
//  - Loads:
//    - LB/LBU take byte o; LH/LHU take halfword at o.
//    - LB/LH sign-extend; LBU/LHU zero-extend; LW is the whole word.
//  - Address wraps modulo DEPTH_WORDS*4; upper bits are ignored.
//  - Illegal funct3 (load 3,6,7; store >=3): no write; rsp_rdata=0.
//  - A store then a load to the same word returns the new data (write completes before the next accept).
// CONFIGURATION
//  `DMEM_MISALIGN_TRAP_EN defined:
//    - A misaligned access (half o[0]!=0, word o!=0) or illegal funct3 sets rsp_err=1.
//    - A misaligned store suppresses its write; rsp_rdata=0.
//  Undefined:
//    - rsp_err tied 0.
//    - Misaligned accesses truncate: half uses o&2, word uses o=0. Write and load proceed.
//    - Illegal funct3 still suppresses the write silently.
// STRUCTURE
//  - defines package: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
//  - defines package: typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_ACCESS, DM_RESP} dmem_state_e.
//  - Sub-module dmem_lane_unit (combinational), from funct3 + offset + data:
//    store byte enables and replicated write data, load extract/extend, misalign flag.
//  - Top holds the FSM, wait counter, request latch, array, response registers.
// TESTING
//  - Reset: assert rst 3 cycles mid-WAIT -> req_ready=1, rsp_valid=0, no response ever for that request.
//  - SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid exactly WAIT_CYCLES+2 after accept.
//  - Load extension after that SW:
//    - LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
//    - LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  - Byte merge: SB 0x55 @0x11 over 0xDEADBEEF -> LW @0x10 = 0xDEAD55EF.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is not accepted.
//  - Misalign, LW @0x12:
//    - trap build: rsp_err=1, rsp_rdata=0.
//    - non-trap build: rsp_err=0, rsp_rdata=word@0x10.
//  - Misalign, SH @0x11: trap build leaves memory unchanged.
//  - Wrap, DEPTH_WORDS=1024: SW 0x12345678 @0x1000 -> LW @0x0 = 0x12345678.

Source files
------------

// File: rtl/dmem_bus_responder_pkg.sv
// Shared definitions for the data-memory bus responder: funct3 encodings,
// the responder state type and a funct3 legality helper.
package dmem_bus_responder_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_ACCESS,
        DM_RESP
    } dmem_state_e;

    // Stores only know SB/SH/SW; loads additionally know the unsigned variants.
    function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
        logic legal;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return legal;
    endfunction

endpackage

// File: rtl/dmem_bus_responder_lane_unit.sv
// Combinational byte-lane unit for the data-memory responder.
// From funct3, byte offset and data it builds store byte enables with
// replicated write data, extracts and extends load data, and flags
// misaligned or illegal accesses. TRAP_EN selects whether a misaligned
// access is dropped and reported, or silently truncated to an aligned one.
module dmem_lane_unit
    import dmem_bus_responder_pkg::*;
#(
    parameter bit TRAP_EN = 1'b0
) (
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        drop_o,
    output logic        err_o
);

    logic [1:0]  eff_off;
    logic        misalign;
    logic        illegal;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Work out the effective offset, then the lanes and load formatting for it.
    always_comb begin
        be_o     = 4'b0000;
        wdata_o  = '0;
        rdata_o  = '0;
        misalign = 1'b0;
        eff_off  = offset_i;
        illegal  = !is_legal_f3(we_i, funct3_i);

        case (funct3_i[1:0])
            2'b01: begin
                misalign = offset_i[0];
                eff_off  = {offset_i[1], 1'b0};
            end
            2'b10: begin
                misalign = |offset_i;
                eff_off  = 2'b00;
            end
            default: ;
        endcase

        sel_byte = rword_i[{eff_off, 3'b000} +: 8];
        sel_half = rword_i[{eff_off[1], 4'b0000} +: 16];

        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << eff_off;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sel_byte[7]}}, sel_byte};
            end
            F3_BU: begin
                rdata_o = {24'h000000, sel_byte};
            end
            F3_H: begin
                be_o    = 4'b0011 << eff_off;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sel_half[15]}}, sel_half};
            end
            F3_HU: begin
                rdata_o = {16'h0000, sel_half};
            end
            F3_W: begin
                be_o    = 4'hF;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: ;
        endcase

        drop_o = illegal || (TRAP_EN && misalign);
        err_o  = TRAP_EN && (illegal || misalign);
    end

endmodule

// File: rtl/dmem_bus_responder.sv
// Responder end of the MEM-stage data-memory interface.
// Accepts one load/store over a valid/ready handshake, waits WAIT_CYCLES,
// performs the array access, then holds the response until it is taken.
// Optional build macro: DMEM_MISALIGN_TRAP_EN reports misaligned or illegal
// accesses on rsp_err_o and drops them; without it misaligned accesses are
// truncated to an aligned one and rsp_err_o stays 0.
module dmem_bus_responder
    import dmem_bus_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [IDX_W+1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rword;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] lane_rdata;
    logic                  lane_drop;
    logic                  lane_err;
    logic                  mem_we;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:IDX_W+2];
    assign idx            = addr_q[IDX_W+1:2];
    assign rword          = mem_q[idx];
    assign mem_we         = (state_q == DM_ACCESS) && we_q && !lane_drop && !rst_i;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;

    dmem_lane_unit #(
        .TRAP_EN (TRAP_EN)
    ) u_lane (
        .we_i     (we_q),
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rword_i  (rword),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata),
        .drop_o   (lane_drop),
        .err_o    (lane_err)
    );

    // Next-state and handshake outputs for the request/response sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;

        case (state_q)
            DM_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i[IDX_W+1:0];
                    wdata_d  = req_wdata_i;
                    cnt_d    = WAIT_LOAD;
                    state_d  = (WAIT_CYCLES == 0) ? DM_ACCESS : DM_WAIT;
                end
            end
            DM_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DM_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DM_ACCESS: begin
                rsp_rdata_d = (we_q || lane_drop) ? '0 : lane_rdata;
                rsp_err_d   = lane_err;
                state_d     = DM_RESP;
            end
            DM_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = DM_IDLE;
                end
            end
            default: state_d = DM_IDLE;
        endcase
    end

    // Control, request latch and response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= DM_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-enable write into the word array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) begin
                    mem_q[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Self-checking bench for dmem_bus_responder (default WAIT_CYCLES=2,
// DEPTH_WORDS=1024). Expected responses are queued when a request is issued
// and popped when the DUT answers. Build with DMEM_MISALIGN_TRAP_EN defined
// to check the trapping variant.
module tb_dmem_bus_responder;
    import dmem_bus_responder_pkg::*;

    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH_WORDS = 1024;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    rsp_t        exp_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] word10;

    dmem_bus_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic txn_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
        txn_t t;
        t.we = we; t.f3 = f3; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.err = err;
        return t;
    endfunction

    // Issues one request and collects its response (rsp_ready held high).
    // lat counts rising edges from and including the accept edge up to the
    // edge after which rsp_valid is first seen. Called and returns at #1 after posedge.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output bit ok);
        int guard;
        ok = 1'b0; rdata = '0; err = 1'b0; lat = 0;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        if (rsp_valid !== 1'b1) return;
        rdata = rsp_rdata; err = rsp_err; ok = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests_run++;
        if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 00000000", rsp_rdata); end
        tests_run++;
        if (rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midwait();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e; bit seen;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(1'b1, F3_W, 32'h40, 32'h11111111, rd, er, lat, ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || rd !== e.rdata || er !== e.err) begin
            tests_failed++; $display("[TB] FAIL midwait_first_sw: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", ok, rd, er, e.rdata, e.err);
        end
        req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h22222222; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midwait_busy: got req_ready=%b expected 0", req_ready); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL midwait_reset_state: got req_ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin tests_failed++; $display("[TB] FAIL midwait_no_rsp: got rsp_valid=1 expected none"); end
        exp_q.push_back('{rdata: 32'h11111111, err: 1'b0});
        run_txn(1'b0, F3_W, 32'h40, 32'h0, rd, er, lat, ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || rd !== e.rdata || er !== e.err) begin
            tests_failed++; $display("[TB] FAIL midwait_store_dropped: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", ok, rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e;
        txn_t t[$];
        t.push_back(mk(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0));
        t.push_back(mk(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
        foreach (t[i]) begin
            exp_q.push_back('{rdata: t[i].rdata, err: t[i].err});
            run_txn(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, er, lat, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                tests_failed++; $display("[TB] FAIL store_load[%0d]: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", i, ok, rd, er, e.rdata, e.err);
            end
            tests_run++;
            if (lat !== WAIT_CYCLES + 2) begin
                tests_failed++; $display("[TB] FAIL latency[%0d]: got %0d expected %0d", i, lat, WAIT_CYCLES + 2);
            end
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e;
        txn_t t[$];
        t.push_back(mk(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0));
        t.push_back(mk(1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0));
        t.push_back(mk(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0));
        t.push_back(mk(1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0));
        t.push_back(mk(1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0));
        t.push_back(mk(1'b0, F3_BU, 32'h11, 32'h0, 32'h000000BE, 1'b0));
        foreach (t[i]) begin
            exp_q.push_back('{rdata: t[i].rdata, err: t[i].err});
            run_txn(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, er, lat, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                tests_failed++; $display("[TB] FAIL load_ext[%0d]: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", i, ok, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e;
        txn_t t[$];
        t.push_back(mk(1'b1, F3_B, 32'h11, 32'hAABBCC55, 32'h0, 1'b0));
        t.push_back(mk(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0));
        foreach (t[i]) begin
            exp_q.push_back('{rdata: t[i].rdata, err: t[i].err});
            run_txn(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, er, lat, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                tests_failed++; $display("[TB] FAIL byte_merge[%0d]: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", i, ok, rd, er, e.rdata, e.err);
            end
        end
        word10 = 32'hDEAD55EF;
    endtask

    task automatic test_backpressure();
        rsp_t e; int guard; bit stable; logic [31:0] first;
        rsp_ready = 1'b0;
        exp_q.push_back('{rdata: word10, err: 1'b0});
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 60) begin @(posedge clk); #1; guard++; end
        e = exp_q.pop_front();
        first = rsp_rdata;
        tests_run++;
        if (rsp_valid !== 1'b1 || first !== e.rdata || rsp_err !== e.err) begin
            tests_failed++; $display("[TB] FAIL bp_rsp: got valid=%b rdata=%h err=%b expected rdata=%h err=%b", rsp_valid, first, rsp_err, e.rdata, e.err);
        end
        req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0) stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++; $display("[TB] FAIL bp_hold: got valid=%b rdata=%h req_ready=%b expected 1/%h/0", rsp_valid, rsp_rdata, req_ready, e.rdata);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL bp_release: got valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e;
        logic [31:0] after_sh;
        txn_t t[$];
        after_sh = TRAP ? word10 : {word10[31:16], 16'hAAAA};
        t.push_back(mk(1'b0, F3_W, 32'h12, 32'h0, TRAP ? 32'h0 : word10, TRAP));
        t.push_back(mk(1'b1, F3_H, 32'h11, 32'h0000AAAA, 32'h0, TRAP));
        t.push_back(mk(1'b0, F3_W, 32'h10, 32'h0, after_sh, 1'b0));
        foreach (t[i]) begin
            exp_q.push_back('{rdata: t[i].rdata, err: t[i].err});
            run_txn(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, er, lat, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                tests_failed++; $display("[TB] FAIL misalign[%0d]: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", i, ok, rd, er, e.rdata, e.err);
            end
        end
        word10 = after_sh;
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e;
        txn_t t[$];
        t.push_back(mk(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, TRAP));
        t.push_back(mk(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, TRAP));
        t.push_back(mk(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, TRAP));
        t.push_back(mk(1'b1, F3_BU, 32'h10, 32'hFFFFFFFF, 32'h0, TRAP));
        t.push_back(mk(1'b0, F3_W, 32'h10, 32'h0, word10, 1'b0));
        foreach (t[i]) begin
            exp_q.push_back('{rdata: t[i].rdata, err: t[i].err});
            run_txn(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, er, lat, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                tests_failed++; $display("[TB] FAIL illegal[%0d]: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", i, ok, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e;
        txn_t t[$];
        t.push_back(mk(1'b1, F3_W, 32'h1000, 32'h12345678, 32'h0, 1'b0));
        t.push_back(mk(1'b0, F3_W, 32'h0, 32'h0, 32'h12345678, 1'b0));
        t.push_back(mk(1'b0, F3_W, 32'hFFFFF000, 32'h0, 32'h12345678, 1'b0));
        foreach (t[i]) begin
            exp_q.push_back('{rdata: t[i].rdata, err: t[i].err});
            run_txn(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, er, lat, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || rd !== e.rdata || er !== e.err) begin
                tests_failed++; $display("[TB] FAIL wrap[%0d]: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", i, ok, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; bit ok; rsp_t e;
        logic [31:0] a; logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            a = 32'h100 + (32'($urandom_range(0, 63)) << 2);
            d = $urandom;
            exp_q.push_back('{rdata: 32'h0, err: 1'b0});
            exp_q.push_back('{rdata: d, err: 1'b0});
            for (int k = 0; k < 2; k++) begin
                run_txn(k == 0, F3_W, a, d, rd, er, lat, ok);
                e = exp_q.pop_front();
                tests_run++;
                if (!ok || rd !== e.rdata || er !== e.err) begin
                    tests_failed++; $display("[TB] FAIL back_to_back[%0d.%0d]: got ok=%b rdata=%h err=%b expected rdata=%h err=%b", i, k, ok, rd, er, e.rdata, e.err);
                end
            end
        end
    endtask

    // Bounds the whole run so a stuck DUT cannot hang the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Runs each scenario in turn and reports the totals.
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; word10 = '0;
        test_reset();
        test_reset_midwait();
        test_store_load();
        test_load_ext();
        test_byte_merge();
        test_backpressure();
        test_misalign();
        test_illegal();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
